icache_ret_line_buf: RTL and testbench

Parametrised return buffer for the instruction-cache refill path. It sits between the AXI read-data channel and the ICache data-bank write port. It assembles a full cache line from read beats and tracks which words are valid. It forwards the requested fetch window as soon as those words arrive (early restart), so the fetch stage does not wait for the whole line.

---
 rtl/icache_ret_line_buf_pkg.sv | 20 ++
 rtl/icache_fetch_window_mux.sv | 51 +++++
 rtl/icache_ret_line_buf.sv | 144 ++++++++++++++
 tb/tb_icache_ret_line_buf.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/icache_ret_line_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : icache_ret_line_buf_pkg
// Brief    : Shared refill-buffer state encoding and default geometry constants.
// Revision : 1.0 - initial release
// ============================================================================
package icache_ret_line_buf_pkg;

    localparam int unsigned DEF_DATA_W      = 32;
    localparam int unsigned DEF_LINE_WORDS  = 4;
    localparam int unsigned DEF_FETCH_WORDS = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } rlb_state_t;

endpackage
`default_nettype wire

// File: rtl/icache_fetch_window_mux.sv
`default_nettype none
// ============================================================================
// Module   : icache_fetch_window_mux
// Brief    : Selects FETCH_WORDS words starting at offset; slots past the line end are masked.
// Revision : 1.0 - initial release
// ============================================================================
module icache_fetch_window_mux
    import icache_ret_line_buf_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int LINE_WORDS  = DEF_LINE_WORDS,
    parameter int FETCH_WORDS = DEF_FETCH_WORDS,
    parameter int OFF_W       = $clog2(LINE_WORDS)
) (
    input  logic [LINE_WORDS*DATA_W-1:0]  i_line,
    input  logic [LINE_WORDS-1:0]         i_word_valid,
    input  logic [OFF_W-1:0]              i_offset,
    output logic [FETCH_WORDS*DATA_W-1:0] o_data,
    output logic [FETCH_WORDS-1:0]        o_mask,
    output logic                          o_all_present
);

    localparam logic [OFF_W:0] c_LINE_END = LINE_WORDS[OFF_W:0];

    logic [DATA_W-1:0]      w_words [LINE_WORDS];
    logic [FETCH_WORDS-1:0] w_present;

    for (genvar k = 0; k < LINE_WORDS; k++) begin : g_unpack
        assign w_words[k] = i_line[k*DATA_W +: DATA_W];
    end

    for (genvar j = 0; j < FETCH_WORDS; j++) begin : g_slot
        localparam logic [OFF_W:0] c_J = (OFF_W+1)'(j);
        logic [OFF_W:0]   w_idx;
        logic [OFF_W-1:0] w_widx;
        logic             w_in;

        // Extra index bit detects slots running past the end of the line.
        assign w_idx  = {1'b0, i_offset} + c_J;
        assign w_widx = w_idx[OFF_W-1:0];
        assign w_in   = (w_idx < c_LINE_END);

        assign o_data[j*DATA_W +: DATA_W] = w_in ? w_words[w_widx] : '0;
        assign o_mask[j]    = w_in;
        assign w_present[j] = ~w_in | i_word_valid[w_widx];
    end

    assign o_all_present = &w_present;

endmodule
`default_nettype wire

// File: rtl/icache_ret_line_buf.sv
`default_nettype none
// ============================================================================
// Module   : icache_ret_line_buf
// Brief    : ICache refill return buffer with early-restart fetch window.
//            ICACHE_RETBUF_WRAP_EN selects critical-word-first WRAP beat order.
// Revision : 1.0 - initial release
// ============================================================================
module icache_ret_line_buf
    import icache_ret_line_buf_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int LINE_WORDS  = DEF_LINE_WORDS,
    parameter int FETCH_WORDS = DEF_FETCH_WORDS,
    parameter int OFF_W       = $clog2(LINE_WORDS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_req_valid,
    input  logic [OFF_W-1:0]              i_req_offset,
    input  logic                          i_rvalid,
    input  logic                          i_rlast,
    input  logic [DATA_W-1:0]             i_rdata,
    output logic                          o_rready,
    output logic [LINE_WORDS*DATA_W-1:0]  o_line,
    output logic                          o_line_valid,
    output logic [FETCH_WORDS*DATA_W-1:0] o_fetch_data,
    output logic [FETCH_WORDS-1:0]        o_fetch_mask,
    output logic                          o_fetch_valid,
    output logic                          o_busy,
    output logic                          o_err
);

    localparam logic [OFF_W:0] c_LINE_END = LINE_WORDS[OFF_W:0];
    localparam logic [OFF_W:0] c_ONE      = {{OFF_W{1'b0}}, 1'b1};

    rlb_state_t             r_state;
    rlb_state_t             w_state_nxt;
    logic [OFF_W-1:0]       r_offset;
    logic [OFF_W:0]         r_beat_cnt;
    logic [OFF_W:0]         w_cnt_inc;
    logic [LINE_WORDS-1:0]  r_word_valid;
    logic [DATA_W-1:0]      r_words [LINE_WORDS];
    logic                   r_err;
    logic [OFF_W-1:0]       w_widx;
    logic                   w_start;
    logic                   w_accept;
    logic                   w_end_err;
    logic [FETCH_WORDS-1:0] w_mask;
    logic                   w_present;

    assign w_cnt_inc = r_beat_cnt + c_ONE;

`ifdef ICACHE_RETBUF_WRAP_EN
    assign w_widx = r_offset + r_beat_cnt[OFF_W-1:0];
`else
    assign w_widx = r_beat_cnt[OFF_W-1:0];
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_accept    = 1'b0;
        w_end_err   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_req_valid) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_FILL;
                end
            end
            ST_FILL: begin
                if (i_rvalid) begin
                    w_accept = 1'b1;
                    if (w_cnt_inc == c_LINE_END) begin
                        w_state_nxt = ST_DONE;
                        w_end_err   = ~i_rlast;
                    end else if (i_rlast) begin
                        w_state_nxt = ST_DONE;
                        w_end_err   = 1'b1;
                    end
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_offset     <= '0;
            r_beat_cnt   <= '0;
            r_word_valid <= '0;
            r_err        <= 1'b0;
            for (int k = 0; k < LINE_WORDS; k++) begin
                r_words[k] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_offset     <= i_req_offset;
                r_beat_cnt   <= '0;
                r_word_valid <= '0;
                r_err        <= 1'b0;
            end
            if (w_accept) begin
                r_words[w_widx]      <= i_rdata;
                r_word_valid[w_widx] <= 1'b1;
                r_beat_cnt           <= w_cnt_inc;
            end
            if (w_end_err) begin
                r_err <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < LINE_WORDS; k++) begin : g_line
        assign o_line[k*DATA_W +: DATA_W] = r_words[k];
    end

    icache_fetch_window_mux #(
        .DATA_W      (DATA_W),
        .LINE_WORDS  (LINE_WORDS),
        .FETCH_WORDS (FETCH_WORDS),
        .OFF_W       (OFF_W)
    ) u_fetch_mux (
        .i_line        (o_line),
        .i_word_valid  (r_word_valid),
        .i_offset      (r_offset),
        .o_data        (o_fetch_data),
        .o_mask        (w_mask),
        .o_all_present (w_present)
    );

    assign o_rready      = (r_state == ST_FILL);
    assign o_busy        = (r_state != ST_IDLE);
    assign o_line_valid  = (r_state == ST_DONE) && !r_err;
    assign o_err         = r_err;
    // Window status is meaningful only while a refill owns the buffer.
    assign o_fetch_mask  = w_mask & {FETCH_WORDS{o_busy}};
    assign o_fetch_valid = o_busy & w_present;

endmodule
`default_nettype wire

// File: tb/tb_icache_ret_line_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_ret_line_buf
// Brief    : Directed self-checking bench for icache_ret_line_buf.
// Revision : 1.0 - initial release
// ============================================================================
module tb_icache_ret_line_buf;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_req_valid;
    logic [1:0]   i_req_offset;
    logic         i_rvalid;
    logic         i_rlast;
    logic [31:0]  i_rdata;
    logic         o_rready;
    logic [127:0] o_line;
    logic         o_line_valid;
    logic [63:0]  o_fetch_data;
    logic [1:0]   o_fetch_mask;
    logic         o_fetch_valid;
    logic         o_busy;
    logic         o_err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    icache_ret_line_buf dut (
        .clk           (clk),
        .rst           (rst),
        .i_req_valid   (i_req_valid),
        .i_req_offset  (i_req_offset),
        .i_rvalid      (i_rvalid),
        .i_rlast       (i_rlast),
        .i_rdata       (i_rdata),
        .o_rready      (o_rready),
        .o_line        (o_line),
        .o_line_valid  (o_line_valid),
        .o_fetch_data  (o_fetch_data),
        .o_fetch_mask  (o_fetch_mask),
        .o_fetch_valid (o_fetch_valid),
        .o_busy        (o_busy),
        .o_err         (o_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [1:0] off);
        i_req_valid  = 1'b1;
        i_req_offset = off;
        tick();
        i_req_valid  = 1'b0;
    endtask

    task automatic beat(input logic [31:0] data, input logic last);
        i_rvalid = 1'b1;
        i_rdata  = data;
        i_rlast  = last;
        tick();
        i_rvalid = 1'b0;
        i_rlast  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++; if (o_busy !== 1'b0) $display("FAIL rst_busy got %h want 0", o_busy); else n_pass++;
        n_checks++; if (o_rready !== 1'b0) $display("FAIL rst_rready got %h want 0", o_rready); else n_pass++;
        n_checks++; if (o_line !== 128'h0) $display("FAIL rst_line got %h want 0", o_line); else n_pass++;
        n_checks++; if (o_line_valid !== 1'b0) $display("FAIL rst_line_valid got %h want 0", o_line_valid); else n_pass++;
        n_checks++; if (o_fetch_valid !== 1'b0) $display("FAIL rst_fetch_valid got %h want 0", o_fetch_valid); else n_pass++;
        n_checks++; if (o_fetch_mask !== 2'b00) $display("FAIL rst_fetch_mask got %h want 0", o_fetch_mask); else n_pass++;
        n_checks++; if (o_fetch_data !== 64'h0) $display("FAIL rst_fetch_data got %h want 0", o_fetch_data); else n_pass++;
        n_checks++; if (o_err !== 1'b0) $display("FAIL rst_err got %h want 0", o_err); else n_pass++;
        rst = 1'b0;
        tick();
    endtask

    // Offset 0 gives the same beat order for INCR and WRAP.
    task automatic test_offset0();
        request(2'd0);
        n_checks++; if (o_rready !== 1'b1) $display("FAIL off0_rready got %h want 1", o_rready); else n_pass++;
        beat(32'h11, 1'b0);
        n_checks++; if (o_fetch_valid !== 1'b0) $display("FAIL off0_fv_beat1 got %h want 0", o_fetch_valid); else n_pass++;
        beat(32'h22, 1'b0);
        n_checks++; if (o_fetch_valid !== 1'b1) $display("FAIL off0_fv_beat2 got %h want 1", o_fetch_valid); else n_pass++;
        n_checks++; if (o_fetch_data !== 64'h00000022_00000011) $display("FAIL off0_fdata got %h want %h", o_fetch_data, 64'h00000022_00000011); else n_pass++;
        n_checks++; if (o_fetch_mask !== 2'b11) $display("FAIL off0_fmask got %h want 3", o_fetch_mask); else n_pass++;
        beat(32'h33, 1'b0);
        n_checks++; if (o_line_valid !== 1'b0) $display("FAIL off0_lv_early got %h want 0", o_line_valid); else n_pass++;
        beat(32'h44, 1'b1);
        n_checks++; if (o_line_valid !== 1'b1) $display("FAIL off0_lv got %h want 1", o_line_valid); else n_pass++;
        n_checks++; if (o_line !== 128'h00000044_00000033_00000022_00000011) $display("FAIL off0_line got %h want %h", o_line, 128'h00000044_00000033_00000022_00000011); else n_pass++;
        n_checks++; if (o_rready !== 1'b0) $display("FAIL off0_rready_done got %h want 0", o_rready); else n_pass++;
        tick();
        n_checks++; if (o_line_valid !== 1'b0) $display("FAIL off0_lv_once got %h want 0", o_line_valid); else n_pass++;
        n_checks++; if (o_busy !== 1'b0) $display("FAIL off0_idle got %h want 0", o_busy); else n_pass++;
        n_checks++; if (o_err !== 1'b0) $display("FAIL off0_err got %h want 0", o_err); else n_pass++;
    endtask

`ifndef ICACHE_RETBUF_WRAP_EN
    task automatic test_incr_off3();
        request(2'd3);
        beat(32'h11, 1'b0);
        beat(32'h22, 1'b0);
        beat(32'h33, 1'b0);
        n_checks++; if (o_fetch_mask !== 2'b01) $display("FAIL off3_mask got %h want 1", o_fetch_mask); else n_pass++;
        n_checks++; if (o_fetch_valid !== 1'b0) $display("FAIL off3_fv_beat3 got %h want 0", o_fetch_valid); else n_pass++;
        beat(32'h44, 1'b1);
        n_checks++; if (o_fetch_valid !== 1'b1) $display("FAIL off3_fv_beat4 got %h want 1", o_fetch_valid); else n_pass++;
        n_checks++; if (o_fetch_data !== 64'h00000000_00000044) $display("FAIL off3_fdata got %h want %h", o_fetch_data, 64'h00000000_00000044); else n_pass++;
        n_checks++; if (o_line_valid !== 1'b1) $display("FAIL off3_lv got %h want 1", o_line_valid); else n_pass++;
        tick();
    endtask
`else
    task automatic test_wrap_off2();
        request(2'd2);
        beat(32'hA, 1'b0);
        n_checks++; if (o_fetch_valid !== 1'b0) $display("FAIL wrap_fv_beat1 got %h want 0", o_fetch_valid); else n_pass++;
        beat(32'hB, 1'b0);
        n_checks++; if (o_fetch_valid !== 1'b1) $display("FAIL wrap_fv_beat2 got %h want 1", o_fetch_valid); else n_pass++;
        n_checks++; if (o_fetch_data !== 64'h0000000B_0000000A) $display("FAIL wrap_fdata got %h want %h", o_fetch_data, 64'h0000000B_0000000A); else n_pass++;
        beat(32'hC, 1'b0);
        beat(32'hD, 1'b1);
        n_checks++; if (o_line !== 128'h0000000B_0000000A_0000000D_0000000C) $display("FAIL wrap_line got %h want %h", o_line, 128'h0000000B_0000000A_0000000D_0000000C); else n_pass++;
        n_checks++; if (o_line_valid !== 1'b1) $display("FAIL wrap_lv got %h want 1", o_line_valid); else n_pass++;
        tick();
    endtask
`endif

    task automatic test_errors();
        request(2'd0);
        beat(32'h1, 1'b0);
        beat(32'h2, 1'b0);
        beat(32'h3, 1'b1);
        n_checks++; if (o_err !== 1'b1) $display("FAIL early_last_err got %h want 1", o_err); else n_pass++;
        n_checks++; if (o_line_valid !== 1'b0) $display("FAIL early_last_lv got %h want 0", o_line_valid); else n_pass++;
        n_checks++; if (o_busy !== 1'b1) $display("FAIL early_last_done got %h want 1", o_busy); else n_pass++;
        tick();
        n_checks++; if (o_busy !== 1'b0) $display("FAIL early_last_idle got %h want 0", o_busy); else n_pass++;
        n_checks++; if (o_err !== 1'b1) $display("FAIL early_last_sticky got %h want 1", o_err); else n_pass++;
        request(2'd0);
        n_checks++; if (o_err !== 1'b0) $display("FAIL err_clear got %h want 0", o_err); else n_pass++;
        beat(32'h5, 1'b0);
        beat(32'h6, 1'b0);
        beat(32'h7, 1'b0);
        beat(32'h8, 1'b0);
        n_checks++; if (o_err !== 1'b1) $display("FAIL no_last_err got %h want 1", o_err); else n_pass++;
        n_checks++; if (o_line_valid !== 1'b0) $display("FAIL no_last_lv got %h want 0", o_line_valid); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid_fill();
        request(2'd0);
        beat(32'hAA, 1'b0);
        beat(32'hBB, 1'b0);
        rst = 1'b1;
        i_req_valid = 1'b1;
        tick();
        i_req_valid = 1'b0;
        n_checks++; if (o_busy !== 1'b0) $display("FAIL midrst_busy got %h want 0", o_busy); else n_pass++;
        n_checks++; if (o_line !== 128'h0) $display("FAIL midrst_line got %h want 0", o_line); else n_pass++;
        n_checks++; if (o_fetch_valid !== 1'b0) $display("FAIL midrst_fv got %h want 0", o_fetch_valid); else n_pass++;
        n_checks++; if ({o_err, o_line_valid, o_rready, o_fetch_mask} !== 5'b0) $display("FAIL midrst_flags got %h want 0", {o_err, o_line_valid, o_rready, o_fetch_mask}); else n_pass++;
        rst = 1'b0;
        tick();
        n_checks++; if (o_line_valid !== 1'b0) $display("FAIL midrst_no_lv got %h want 0", o_line_valid); else n_pass++;
        request(2'd0);
        beat(32'hC1, 1'b0);
        beat(32'hC2, 1'b0);
        beat(32'hC3, 1'b0);
        beat(32'hC4, 1'b1);
        n_checks++; if (o_line !== 128'h000000C4_000000C3_000000C2_000000C1) $display("FAIL refill_line got %h want %h", o_line, 128'h000000C4_000000C3_000000C2_000000C1); else n_pass++;
        n_checks++; if (o_line_valid !== 1'b1) $display("FAIL refill_lv got %h want 1", o_line_valid); else n_pass++;
        tick();
    endtask

    task automatic test_ignored_inputs();
        beat(32'hDEAD, 1'b1);
        n_checks++; if (o_busy !== 1'b0) $display("FAIL idle_beat_busy got %h want 0", o_busy); else n_pass++;
        n_checks++; if (o_line !== 128'h000000C4_000000C3_000000C2_000000C1) $display("FAIL idle_beat_line got %h want %h", o_line, 128'h000000C4_000000C3_000000C2_000000C1); else n_pass++;
        request(2'd0);
        beat(32'h55, 1'b0);
        i_req_valid  = 1'b1;
        i_req_offset = 2'd3;
        beat(32'h66, 1'b0);
        i_req_valid  = 1'b0;
        n_checks++; if (o_fetch_mask !== 2'b11) $display("FAIL fill_req_mask got %h want 3", o_fetch_mask); else n_pass++;
        n_checks++; if (o_fetch_data !== 64'h00000066_00000055) $display("FAIL fill_req_fdata got %h want %h", o_fetch_data, 64'h00000066_00000055); else n_pass++;
        beat(32'h77, 1'b0);
        beat(32'h88, 1'b1);
        n_checks++; if (o_line_valid !== 1'b1) $display("FAIL fill_req_lv got %h want 1", o_line_valid); else n_pass++;
        i_req_valid = 1'b1;
        tick();
        i_req_valid = 1'b0;
        n_checks++; if (o_busy !== 1'b0) $display("FAIL done_req_busy got %h want 0", o_busy); else n_pass++;
        n_checks++; if (o_line !== 128'h00000088_00000077_00000066_00000055) $display("FAIL done_req_line got %h want %h", o_line, 128'h00000088_00000077_00000066_00000055); else n_pass++;
    endtask

    initial begin
        rst          = 1'b1;
        i_req_valid  = 1'b0;
        i_req_offset = 2'd0;
        i_rvalid     = 1'b0;
        i_rlast      = 1'b0;
        i_rdata      = 32'h0;
        test_reset();
        test_offset0();
`ifndef ICACHE_RETBUF_WRAP_EN
        test_incr_off3();
`else
        test_wrap_off2();
`endif
        test_errors();
        test_reset_mid_fill();
        test_ignored_inputs();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
